// File: rtl/reg_share_arb_pkg.sv
// rtl/reg_share_arb_pkg.sv - shared types and helpers for reg_share_arb
// Purpose: arbiter state enum and the index-width helper used to size
// requester indices (q_src, round-robin pointer, pick index).
// Ports: none (package).
package reg_share_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_share_arb_rr_pick.sv
// rtl/reg_share_arb_rr_pick.sv - round-robin first-request picker
// Purpose: combinational search for the first asserted request starting at
// ptr and wrapping past N-1 back to 0.
// Ports:
//   req  [N-1:0]  request vector
//   ptr  [IW-1:0] search start index (always < N)
//   pick [N-1:0]  one-hot of the chosen requester (zero if no request)
//   idx  [IW-1:0] index of the chosen requester (zero if no request)
module rr_pick
  import reg_share_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx
);

  always_comb begin
    int   j;
    logic found;
    j     = 0;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found   = 1'b1;
        pick[j] = 1'b1;
        idx     = IW'(j);
      end
    end
  end

endmodule

// File: rtl/reg_share_arb.sv
// rtl/reg_share_arb.sv - round-robin arbiter sharing one W-bit register
// Purpose: grants one requester at a time, loads its wdata into q on every
// granted cycle with req still high, reports the writer in q_src.
// Optional feature macro: REG_SHARE_ARB_HOLD_LIMIT_EN (forces rotation after
// HOLD_MAX writes per grant; otherwise an owner keeps the grant until req drops).
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-low reset
//   req      [N-1:0]   per-requester level request
//   wdata    [N*W-1:0] packed write data, requester i at [i*W +: W]
//   gnt      [N-1:0]   registered one-hot grant
//   q        [W-1:0]   shared register
//   q_valid  one-cycle pulse after a write edge
//   q_src    index of the requester that last wrote q
module reg_share_arb
  import reg_share_arb_pkg::*;
#(
  parameter int N        = 3,
  parameter int W        = 3,
  parameter int HOLD_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req,
  input  logic [N*W-1:0]         wdata,
  output logic [N-1:0]           gnt,
  output logic [W-1:0]           q,
  output logic                   q_valid,
  output logic [idx_w(N)-1:0]    q_src
);

  localparam int IW = idx_w(N);

  arb_state_e    state, state_d;
  logic [N-1:0]  gnt_d;
  logic [W-1:0]  q_d;
  logic          q_valid_d;
  logic [IW-1:0] q_src_d;
  logic [IW-1:0] ptr, ptr_d;
  logic [IW-1:0] owner, owner_d;
  logic [N-1:0]  pick;
  logic [IW-1:0] pick_idx;

`ifdef REG_SHARE_ARB_HOLD_LIMIT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  logic [CW-1:0] cnt, cnt_d;
`else
  localparam int unused_hold_max = HOLD_MAX;
`endif

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gnt     <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      q_src   <= '0;
      ptr     <= '0;
      owner   <= '0;
`ifdef REG_SHARE_ARB_HOLD_LIMIT_EN
      cnt     <= '0;
`endif
    end else begin
      state   <= state_d;
      gnt     <= gnt_d;
      q       <= q_d;
      q_valid <= q_valid_d;
      q_src   <= q_src_d;
      ptr     <= ptr_d;
      owner   <= owner_d;
`ifdef REG_SHARE_ARB_HOLD_LIMIT_EN
      cnt     <= cnt_d;
`endif
    end
  end

  always_comb begin
    logic release_now;
    state_d     = state;
    gnt_d       = gnt;
    q_d         = q;
    q_valid_d   = 1'b0;
    q_src_d     = q_src;
    ptr_d       = ptr;
    owner_d     = owner;
    release_now = 1'b0;
`ifdef REG_SHARE_ARB_HOLD_LIMIT_EN
    cnt_d       = cnt;
`endif
    case (state)
      IDLE: begin
        gnt_d = '0;
        if (|req) begin
          gnt_d   = pick;
          owner_d = pick_idx;
          state_d = GRANT;
`ifdef REG_SHARE_ARB_HOLD_LIMIT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (req[owner]) begin
          q_d       = wdata[int'(owner)*W +: W];
          q_src_d   = owner;
          q_valid_d = 1'b1;
`ifdef REG_SHARE_ARB_HOLD_LIMIT_EN
          cnt_d     = cnt + CW'(1);
          // The write that reaches the limit also ends the grant.
          release_now = (cnt_d == CW'(HOLD_MAX));
`endif
        end else begin
          release_now = 1'b1;
        end
        if (release_now) begin
          gnt_d   = '0;
          state_d = IDLE;
          ptr_d   = (owner == IW'(N - 1)) ? '0 : owner + IW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

endmodule

// File: doc/reg_share_arb.md
# reg_share_arb

Round-robin arbiter and sequencer that shares a single W-bit holding register among N requesters. Each requester raises a request with its write data; the block grants one requester at a time, loads that requester's data into the shared register, and reports which source wrote it. It sits in front of the shared state registers in the statement datapath, so several producers can update the same registered value without contention.

## Interface
- N, 3, number of requesters (≥2)
- W, 3, data and register width
- HOLD_MAX, 4, max writes per grant before forced rotation (≥1, only with hold-limit feature)

- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- req  input  N  per-requester request, level
- wdata  input  N*W  packed write data, requester i at [i*W +: W]
- gnt  output  N  one-hot grant, registered
- q  output  W  shared register value
- q_valid  output  1  one-cycle pulse: q updated on last edge
- q_src  output  clog2(N)  index of requester that last wrote q

## Operation
- Reset (rst low, async): state IDLE, gnt=0, q=0, q_valid=0, q_src=0, rr pointer=0, hold count=0. Reset mid-grant aborts with no write.
- States: IDLE, GRANT.
- IDLE: if any req, pick first asserted index searching from pointer upward with wrap (pointer, pointer+1, …, N-1, 0, …). Load gnt with that one-hot, clear hold count, go GRANT. No req: stay IDLE, gnt=0.
- GRANT (owner i): a write happens in every cycle with gnt[i] && req[i]: q<=wdata[i], q_src<=i, q_valid<=1 on that edge, hold count+1.
- Release: req[i] low in GRANT → no write, gnt<=0, pointer<=(i+1) mod N, go IDLE.
- Hold limit: the write that brings hold count to HOLD_MAX also releases: gnt<=0, pointer<=(i+1) mod N, go IDLE.
- Requests from non-owners are ignored while in GRANT; they are not latched.
- q_valid is 0 in every cycle not following a write.
- gnt is always zero or one-hot.

## Timing
- Request to grant: req[i] seen high at edge t in IDLE → gnt[i]=1 after edge t.
- Grant to data: first write on edge t+1; q and q_valid visible after edge t+1.
- Rotation bubble: one IDLE cycle between consecutive grants. Max throughput is HOLD_MAX writes per HOLD_MAX+1 cycles.
- Wrap-around: pointer N-1 → 0.
- Simultaneous last write at HOLD_MAX and req drop: handled as a hold-limit release, with the write performed only if req[i] was high.

## Configuration
- REG_SHARE_ARB_HOLD_LIMIT_EN defined: HOLD_MAX enforced as above. The hold counter is clog2(HOLD_MAX+1) bits.
- Not defined: no hold counter and HOLD_MAX unused. The owner keeps the grant until its req drops. Pointer advance on release is unchanged.

## Structure
- Package reg_share_arb_pkg: state enum (IDLE, GRANT), clog2-based index width function.
- Sub-module rr_pick: combinational, inputs req and pointer, outputs one-hot pick and index. Instantiated once.

## Test plan
- Reset: hold rst low, then drive req=3'b111 and deassert rst → gnt=0 until the first edge, then gnt=3'b001. Assert rst mid-GRANT → gnt=0, q=0, q_valid=0 immediately with no clock.
- Single requester: req=3'b010, wdata1=3'h5 from idle → gnt=3'b010 after edge 1, q=5 with q_valid=1 and q_src=1 after edge 2.
- Full contention with macro defined, HOLD_MAX=4, req=3'b111, wdata_i=i+1: owner order is 0, 1, 2, 0 with four writes each and one-cycle gnt=0 gaps. q sequence is 1×4, 2×4, 3×4.
- Early release: owner 0 drops req after 2 writes while req2 is high → one idle cycle, then gnt=3'b100 because the pointer is at 1 and req1 is low.
- Macro undefined: req0 high for 10 cycles with req1 also high → 10 consecutive writes from source 0 with no rotation, then gnt=3'b010 after the idle cycle.
- Coincident drop at limit: owner drops req on the cycle its 4th write would occur → no 4th write, q holds the 3rd value, gnt=0 next cycle, pointer advances.
